// File: rtl/axi_pkg.sv
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI encodings, state types and helpers for the write
//               channel slave and the upstream protocol FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Protocol FSM states, shared with the upstream write-channel master.
    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        COMMIT = 2'd1,
        ASSERT = 2'd2
    } proto_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_t;

    // Bursts this slave cannot service; they are consumed but never written.
    function automatic logic f_burst_err(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [7:0] len
    );
        logic w_bad_wrap_len;
        w_bad_wrap_len = !((len == 8'd1) || (len == 8'd3) ||
                           (len == 8'd7) || (len == 8'd15));
        return (size > 3'd3) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && w_bad_wrap_len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_cur_addr,
    input  logic [2:0]    i_size,
    input  logic [7:0]    i_len,
    input  logic [1:0]    i_burst,
    output logic [AW-1:0] o_next_addr
);

    localparam logic [AW-1:0] c_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] w_inc;
    logic [AW-1:0] w_align_mask;
    logic [AW-1:0] w_wrap_mask;
    logic [AW-1:0] w_len_plus1;

    assign w_inc        = c_ONE << i_size;
    assign w_align_mask = w_inc - c_ONE;
    assign w_len_plus1  = {{(AW-8){1'b0}}, i_len} + c_ONE;
    // Only meaningful for legal wrap lengths, where (len+1)*inc is a power of two.
    assign w_wrap_mask  = (w_len_plus1 << i_size) - c_ONE;

    always_comb begin
        o_next_addr = i_cur_addr;
        case (i_burst)
            BURST_INCR: o_next_addr = (i_cur_addr & ~w_align_mask) + w_inc;
            BURST_WRAP: o_next_addr = (i_cur_addr & ~w_wrap_mask) |
                                      ((i_cur_addr + w_inc) & w_wrap_mask);
            default:    o_next_addr = i_cur_addr;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axi_wr_slave_mem.sv
// ============================================================================
// Module      : axi_wr_slave_mem
// Description : AXI write slave into a byte-writable word memory with a
//               registered read-back port. Optional macro WLAST_CHECK_EN
//               flags wlast/beat-count disagreement as SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wr_slave_mem
    import axi_pkg::*;
#(
    parameter int AW     = 32,
    parameter int MEM_AW = 6,
    parameter int DW     = 64
) (
    input  logic              axi_aclk,
    input  logic              rst,
    input  logic [AW-1:0]     axi_awaddr,
    input  logic [7:0]        axi_awlen,
    input  logic [2:0]        axi_awsize,
    input  logic [1:0]        axi_awburst,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [DW-1:0]     axi_wdata,
    input  logic [DW/8-1:0]   axi_wstrb,
    input  logic              axi_wlast,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic [MEM_AW-1:0] mem_raddr,
    output logic [DW-1:0]     mem_rdata
);

    localparam int c_WORDS = 2 ** MEM_AW;

    wr_state_t         r_state;
    wr_state_t         w_next_state;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     w_next_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_beat_cnt;
    logic              r_err;

    logic [DW-1:0]     r_mem [0:c_WORDS-1];
    logic [DW-1:0]     r_rdata;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_last_beat;
    logic              w_wlast_err;
    logic              w_mem_we;
    logic [MEM_AW-1:0] w_mem_idx;

    assign w_aw_hs     = axi_awvalid & r_awready;
    assign w_w_hs      = axi_wvalid & r_wready;
    assign w_b_hs      = r_bvalid & axi_bready;
    assign w_last_beat = (r_beat_cnt == r_len);
    // Upper address bits beyond the memory are dropped, so the memory aliases.
    assign w_mem_idx   = r_addr[MEM_AW+2:3];
    assign w_mem_we    = w_w_hs & ~r_err & ~rst;

`ifdef WLAST_CHECK_EN
    assign w_wlast_err = axi_wlast ^ w_last_beat;
`else
    logic w_unused_wlast;
    assign w_unused_wlast = axi_wlast;
    assign w_wlast_err    = 1'b0;
`endif

    axi_burst_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .i_cur_addr  (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_aw_hs)                 w_next_state = DATA;
            DATA:    if (w_w_hs && w_last_beat)   w_next_state = RESP;
            RESP:    if (w_b_hs)                  w_next_state = IDLE;
            default:                              w_next_state = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state, never from valid.
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_awready <= (w_next_state == IDLE);
            r_wready  <= (w_next_state == DATA);
            r_bvalid  <= (w_next_state == RESP);
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= BURST_FIXED;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_addr     <= axi_awaddr;
                r_len      <= axi_awlen;
                r_size     <= axi_awsize;
                r_burst    <= axi_awburst;
                r_beat_cnt <= '0;
                r_err      <= f_burst_err(axi_awsize, axi_awburst, axi_awlen);
            end
            if (w_w_hs) begin
                r_addr     <= w_next_addr;
                r_beat_cnt <= r_beat_cnt + 8'd1;
                if (w_wlast_err) begin
                    r_err <= 1'b1;
                end
                if (w_last_beat) begin
                    r_bresp <= (r_err | w_wlast_err) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Read samples before the write lands, so a colliding read sees old data.
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[mem_raddr];
        end
        if (w_mem_we) begin
            for (int i = 0; i < DW/8; i++) begin
                if (axi_wstrb[i]) begin
                    r_mem[w_mem_idx][i*8 +: 8] <= axi_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;
    assign mem_rdata   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_slave_mem.sv
// ============================================================================
// Module      : tb_axi_wr_slave_mem
// Description : Randomized scoreboard bench for axi_wr_slave_mem against a
//               behavioural memory/burst model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_wr_slave_mem;

    localparam int AW     = 32;
    localparam int MEM_AW = 6;
    localparam int DW     = 64;
    localparam int NW     = 64;

    logic              axi_aclk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     axi_awaddr = '0;
    logic [7:0]        axi_awlen = '0;
    logic [2:0]        axi_awsize = '0;
    logic [1:0]        axi_awburst = '0;
    logic              axi_awvalid = 1'b0;
    logic              axi_awready;
    logic [DW-1:0]     axi_wdata = '0;
    logic [DW/8-1:0]   axi_wstrb = '0;
    logic              axi_wlast = 1'b0;
    logic              axi_wvalid = 1'b0;
    logic              axi_wready;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready = 1'b0;
    logic [MEM_AW-1:0] mem_raddr = '0;
    logic [DW-1:0]     mem_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] ref_mem [NW];
    logic [1:0]  b_q [$];
    logic [63:0] r_q [$];
    logic [63:0] dq [$];
    logic [7:0]  sq [$];
    logic        rd_req = 1'b0;
    logic        rd_fire = 1'b0;

    axi_wr_slave_mem #(.AW(AW), .MEM_AW(MEM_AW), .DW(DW)) dut (
        .axi_aclk    (axi_aclk),
        .rst         (rst),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting, required a DUT response at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_err(input int len, input int size, input int burst);
        return (size > 3) || (burst == 3) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input int len,
                                           input int size, input int burst);
        longint unsigned ua, inc, bnd, base;
        ua  = 64'(a);
        inc = 64'd1 << size;
        if (burst == 1) return 32'((ua / inc) * inc + inc);
        if (burst == 2) begin
            bnd  = 64'(len + 1) * inc;
            base = (ua / bnd) * bnd;
            return 32'(base + (ua - base + inc) % bnd);
        end
        return a;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [5:0] idx;
        idx = a[8:3];
        for (int i = 0; i < 8; i++)
            if (s[i]) ref_mem[idx][i*8 +: 8] = d[i*8 +: 8];
    endfunction

    // ---------------- monitors ----------------
    always @(posedge axi_aclk) rd_fire <= rd_req;

    always @(negedge axi_aclk) begin
        if (rd_fire) begin
            if (r_q.size() == 0) tmo("rdata_unexpected");
            else chk("rdata", mem_rdata, r_q.pop_front());
        end
        if (axi_bvalid && axi_bready) begin
            if (b_q.size() == 0) tmo("bresp_unexpected");
            else chk("bresp", 64'(axi_bresp), 64'(b_q.pop_front()));
        end
    end

    // ---------------- stimulus tasks (entered at posedge+1) ----------------
    task automatic aw_send(input logic [31:0] a, input int len, input int size, input int burst);
        logic ok = 1'b0;
        axi_awaddr  = a;
        axi_awlen   = 8'(len);
        axi_awsize  = 3'(size);
        axi_awburst = 2'(burst);
        axi_awvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge axi_aclk);
            if (axi_awready) begin ok = 1'b1; break; end
        end
        if (!ok) tmo("aw_accept");
        @(posedge axi_aclk); #1;
        axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic last, input int gap);
        logic ok = 1'b0;
        repeat (gap) begin @(posedge axi_aclk); #1; end
        axi_wdata  = d;
        axi_wstrb  = s;
        axi_wlast  = last;
        axi_wvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge axi_aclk);
            if (axi_wready) begin ok = 1'b1; break; end
        end
        if (!ok) tmo("w_accept");
        @(posedge axi_aclk); #1;
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
    endtask

    task automatic b_finish(input logic [1:0] exp, input int hold);
        logic ok = 1'b0;
        b_q.push_back(exp);
        for (int n = 0; n < 100; n++) begin
            @(negedge axi_aclk);
            if (axi_bvalid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            tmo("b_valid");
            void'(b_q.pop_back());
            @(posedge axi_aclk); #1;
            return;
        end
        for (int k = 0; k < hold; k++) begin
            chk("bvalid_hold", 64'(axi_bvalid), 64'd1);
            chk("bresp_hold", 64'(axi_bresp), 64'(exp));
            @(posedge axi_aclk); #1;
            @(negedge axi_aclk);
        end
        chk("awready_in_resp", 64'(axi_awready), 64'd0);
        @(posedge axi_aclk); #1;
        axi_bready = 1'b1;
        @(posedge axi_aclk); #1;
        axi_bready = 1'b0;
        @(negedge axi_aclk);
        chk("awready_after_b", 64'(axi_awready), 64'd1);
        chk("bvalid_after_b", 64'(axi_bvalid), 64'd0);
        @(posedge axi_aclk); #1;
    endtask

    // Beat data/strobes come from dq/sq when present, else random.
    task automatic run_burst(input logic [31:0] a, input int len, input int size,
                             input int burst, input int hold, input int bad, input int gap_max);
        logic [31:0] cur;
        logic [63:0] d;
        logic [7:0]  s;
        logic        err;
        logic [1:0]  exp;
        cur = a;
        err = m_err(len, size, burst);
        exp = err ? 2'b10 : 2'b00;
        aw_send(a, len, size, burst);
        for (int b = 0; b <= len; b++) begin
            d = (dq.size() > b) ? dq[b] : {$urandom, $urandom};
            s = (sq.size() > b) ? sq[b] : 8'($urandom);
            w_send(d, s, (b == len) ^ (b == bad), $urandom_range(0, gap_max));
            if (!err) m_write(cur, d, s);
            cur = m_next(cur, len, size, burst);
        end
`ifdef WLAST_CHECK_EN
        if (bad >= 0 && bad <= len) exp = 2'b10;
`endif
        dq.delete();
        sq.delete();
        b_finish(exp, hold);
    endtask

    task automatic rd_word(input int idx, input logic [63:0] exp);
        mem_raddr = 6'(idx);
        rd_req    = 1'b1;
        r_q.push_back(exp);
        @(posedge axi_aclk); #1;
    endtask

    task automatic rd_done();
        rd_req = 1'b0;
        @(posedge axi_aclk); #1;
    endtask

    task automatic rd_all();
        for (int i = 0; i < NW; i++) rd_word(i, ref_mem[i]);
        rd_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d0, d1;
        int len, burst;

        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("rst_awready", 64'(axi_awready), 64'd1);
        chk("rst_wready", 64'(axi_wready), 64'd0);
        chk("rst_bvalid", 64'(axi_bvalid), 64'd0);
        chk("rst_bresp", 64'(axi_bresp), 64'd0);
        chk("rst_rdata", mem_rdata, 64'd0);
        @(posedge axi_aclk); #1;
        rst = 1'b0;

        // W before AW must wait
        axi_wvalid = 1'b1;
        repeat (3) begin
            @(negedge axi_aclk);
            chk("wready_idle", 64'(axi_wready), 64'd0);
            @(posedge axi_aclk); #1;
        end
        axi_wvalid = 1'b0;

        // Fill the whole memory with known data
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 16; b++) sq.push_back(8'hFF);
            run_burst(32'(j * 128), 15, 3, 1, 0, -1, 1);
        end
        rd_all();

        // INCR single beat
        dq.push_back(64'h1122334455667788); sq.push_back(8'hFF);
        run_burst(32'h10, 0, 3, 1, 0, -1, 0);
        rd_word(2, 64'h1122334455667788);
        rd_done();

        // INCR 4 beats
        for (int b = 1; b <= 4; b++) begin dq.push_back(64'(b)); sq.push_back(8'hFF); end
        run_burst(32'h0, 3, 3, 1, 0, -1, 0);
        for (int i = 0; i < 4; i++) rd_word(i, 64'(i + 1));
        rd_done();

        // WRAP 4 beats from 0x30
        for (int b = 0; b < 4; b++) begin dq.push_back(64'hA0 + 64'(b)); sq.push_back(8'hFF); end
        run_burst(32'h30, 3, 3, 2, 0, -1, 0);
        rd_word(6, 64'hA0); rd_word(7, 64'hA1); rd_word(4, 64'hA2); rd_word(5, 64'hA3);
        rd_done();

        // FIXED with strobes
        dq.push_back(64'hFFFF_FFFF_FFFF_FFFF); sq.push_back(8'h0F);
        dq.push_back(64'h0);                   sq.push_back(8'hF0);
        run_burst(32'h8, 1, 3, 0, 0, -1, 0);
        rd_word(1, 64'h0000_0000_FFFF_FFFF);
        rd_done();

        // Error bursts: consumed, no writes, SLVERR held while bready low
        run_burst(32'h0, 2, 4, 1, 5, -1, 1);
        run_burst(32'h40, 1, 3, 3, 5, -1, 1);
        rd_all();

        // Randomized bursts
        for (int t = 0; t < 25; t++) begin
            burst = $urandom_range(0, 3);
            len   = $urandom_range(0, 15);
            if (burst == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            run_burst($urandom, len, ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3),
                      burst, $urandom_range(0, 3), -1, 2);
        end
        rd_all();

        // Reset after 2 of 4 beats
        aw_send(32'h0, 3, 3, 1);
        d0 = {$urandom, $urandom};
        d1 = {$urandom, $urandom};
        w_send(d0, 8'hFF, 1'b0, 0); m_write(32'h0, d0, 8'hFF);
        w_send(d1, 8'hFF, 1'b0, 0); m_write(32'h8, d1, 8'hFF);
        rst = 1'b1;
        @(posedge axi_aclk); #1;
        rst = 1'b0;
        @(negedge axi_aclk);
        chk("midrst_awready", 64'(axi_awready), 64'd1);
        chk("midrst_wready", 64'(axi_wready), 64'd0);
        chk("midrst_bvalid", 64'(axi_bvalid), 64'd0);
        @(posedge axi_aclk); #1;
        for (int i = 0; i < 4; i++) rd_word(i, ref_mem[i]);
        rd_done();

`ifdef WLAST_CHECK_EN
        run_burst(32'h40, 3, 3, 1, 0, 1, 0);
        run_burst(32'h80, 3, 3, 1, 0, 3, 0);
`endif
        run_burst(32'hC0, 3, 3, 1, 0, -1, 0);
        rd_all();

        chk("bq_drained", 64'(b_q.size()), 64'd0);
        chk("rq_drained", 64'(r_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_wr_slave_mem.md
Name: axi_wr_slave_mem

Overview:
- AXI write-side slave at the downstream end of the write-channel protocol FSM.
- Consumes the AW and W channel outputs (axi_aw*, axi_w*), drives the matching ready signals, and returns the B response.
- Each beat is written byte-wise into an internal word-addressed memory.
- A registered read-back port lets benches and downstream checkers inspect memory contents.

Parameters:
- AW, 32, byte address width.
- MEM_AW, 6, memory word-index width (2^MEM_AW words of 64 bits).
- DW, 64, data width; fixed, with 8 strobe bits.

Ports:
- axi_aclk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- axi_awaddr  in  AW  burst start byte address.
- axi_awlen  in  8  beats minus one.
- axi_awsize  in  3  log2 bytes per beat.
- axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- axi_awvalid  in  1  address valid.
- axi_awready  out  1  address accepted.
- axi_wdata  in  64  beat data.
- axi_wstrb  in  8  byte enables.
- axi_wlast  in  1  final beat flag.
- axi_wvalid  in  1  data valid.
- axi_wready  out  1  data accepted.
- axi_bresp  out  2  00 OKAY, 10 SLVERR.
- axi_bvalid  out  1  response valid.
- axi_bready  in  1  response accepted.
- mem_raddr  in  MEM_AW  read-back word index.
- mem_rdata  out  64  word at mem_raddr, registered, 1-cycle latency.

Behaviour:
- Reset values:
  - axi_awready=1, axi_wready=0, axi_bvalid=0, axi_bresp=00, mem_rdata=0.
  - FSM goes to IDLE; beat counter and error flag are cleared.
  - Memory contents are not reset.
- Handshake: a transfer occurs on any cycle where valid&&ready. Ready outputs are registered and never depend combinationally on valid.
- IDLE (awready=1, wready=0):
  - On an AW handshake, latch addr/len/size/burst, set beat_cnt=0 and err=0.
  - Set err if awsize>3, if awburst==11, or if awburst==WRAP and awlen is not in {1,3,7,15}.
  - Next state DATA: awready=0, wready=1. Next AW accept is no earlier than one cycle after the B handshake.
- DATA (wready=1):
  - On each W handshake, write bytes i where wstrb[i]=1 into mem[cur_addr[MEM_AW+2:3]].
    - The write is suppressed entirely if err is set.
    - Index bits above MEM_AW+2 are ignored (memory aliases).
  - Address step per beat uses inc = 1<<awsize:
    - FIXED: cur_addr is unchanged.
    - INCR: cur_addr = (cur_addr & ~(inc-1)) + inc, truncated to AW bits.
    - WRAP: boundary = (awlen+1)*inc. Low bits within the boundary wrap; upper bits are held.
  - beat_cnt increments, 8-bit.
  - Burst ends on the handshake where beat_cnt==awlen. Next state RESP: wready=0, bvalid=1, bresp = err ? 10 : 00.
  - No W beats are accepted in IDLE or RESP. wvalid arriving before AW simply waits.
- RESP (bvalid=1):
  - Held with bresp stable until bready.
  - On the B handshake: bvalid=0, awready=1, state IDLE.
- Read port: mem_rdata <= mem[mem_raddr] every cycle. A same-cycle write to the same word returns the old data.
- Reset mid-burst:
  - Abandons the burst and returns to IDLE with the reset values above.
  - Beats already written remain in memory.
- awlen=0: exactly one beat; RESP follows that handshake directly.

Optional Feature:
- Macro WLAST_CHECK_EN.
- Defined:
  - wlast=1 on a beat with beat_cnt!=awlen, or wlast=0 on the final beat, sets err for the response.
  - Writes already issued for the current beat still occur.
  - The burst still terminates on the count.
- Undefined: axi_wlast is ignored, with no logic generated for it.

Decomposition:
- Shared package axi_pkg:
  - Burst encodings BURST_FIXED/INCR/WRAP.
  - Response encodings RESP_OKAY/RESP_SLVERR.
  - FSM state encodings WAIT/COMMIT/ASSERT, shared with the protocol FSM.
  - This block's state typedef IDLE/DATA/RESP.
- One sub-module, axi_burst_addr_gen: combinational next-address from (cur_addr, size, len, burst). It is reused later by the read slave.

Test Plan:
- INCR single beat: awaddr=0x10, awlen=0, awsize=3, wdata=0x1122334455667788, wstrb=FF -> bresp=00; one cycle after mem_raddr=2, mem_rdata=0x1122334455667788.
- INCR 4 beats: awaddr=0x0, awlen=3, size=3, data 1..4 -> words 0..3 hold 1..4, bresp=00, awready rises the cycle after the B handshake.
- WRAP 4 beats: awaddr=0x30, awlen=3, size=3 -> beats land in words 6,7,4,5.
- Strobes and FIXED: awburst=00, awaddr=0x8, awlen=1, beat0 wstrb=0F data all-ones, beat1 wstrb=F0 data 0 -> word1 = 0x00000000FFFFFFFF.
- Error: awsize=4 or awburst=11 -> all beats accepted, memory unchanged, bresp=10. Separately, bready held low 5 cycles -> bvalid and bresp stable throughout.
- Reset in DATA after 2 of 4 beats -> awready=1, wready=0, bvalid=0 next cycle; words 0..1 written. With WLAST_CHECK_EN, wlast=1 on beat 1 of 4 -> bresp=10.
